// File: rtl/ppc_pkg.sv
// Shared types and default sizes for the photon pulse conditioner.
package ppc_pkg;

    localparam int DT_W_DEF   = 8;
    localparam int ST_W_DEF   = 8;
    localparam int REJ_W_DEF  = 16;
    localparam int SYNC_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        OPEN
    } ppc_state_e;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for an asynchronous level, followed by a registered
// rising-edge detector. `rise` is high for one cycle per synchronised 0->1.
module sync_edge
    import ppc_pkg::*;
#(
    parameter int DEPTH = SYNC_DEPTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic rise
);

    logic [DEPTH-1:0] sync_q;
    logic             last_q;

    // NOTE: every flop in a clocked process uses <= so all registers update
    // from pre-edge values; a blocking = here would collapse the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], raw};
            last_q <= sync_q[DEPTH-1];
        end
    end

    assign rise = sync_q[DEPTH-1] & ~last_q;

endmodule

// File: rtl/photon_pulse_conditioner.sv
// Photon/DMD front end: synchronises both inputs, runs the settle-blanking FSM,
// gates photon strobes and counts rejects per frame. PPC_DEADTIME_EN adds holdoff.
module photon_pulse_conditioner
    import ppc_pkg::*;
#(
    parameter int DT_W  = DT_W_DEF,
    parameter int ST_W  = ST_W_DEF,
    parameter int REJ_W = REJ_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig,
    input  logic             DMD_sig,
    input  logic             enable,
    input  logic [DT_W-1:0]  deadtime,
    input  logic [ST_W-1:0]  settle,
    output logic             photon_pulse,
    output logic             frame_tick,
    output logic             window,
    output logic [REJ_W-1:0] reject_cnt,
    output logic [REJ_W-1:0] reject_last
);

    logic             photon_rise;
    logic             dmd_rise;
    ppc_state_e       state;
    ppc_state_e       next_state;
    logic [ST_W-1:0]  settle_cnt;
    logic [ST_W-1:0]  next_settle_cnt;
    logic             settle_zero;
    logic             holdoff_clear;
    logic             accept;
    logic             reject;
    logic             tick;
    logic [REJ_W-1:0] reject_sum;

    sync_edge u_sync_sig (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (sig),
        .rise  (photon_rise)
    );

    sync_edge u_sync_dmd (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (DMD_sig),
        .rise  (dmd_rise)
    );

    assign settle_zero = (settle == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
        end else begin
            state      <= next_state;
            settle_cnt <= next_settle_cnt;
        end
    end

    // NOTE: defaults first so every path assigns every output; otherwise the
    // tool infers latches to hold the unassigned values.
    always_comb begin
        next_state      = state;
        next_settle_cnt = settle_cnt;
        if (!enable) begin
            next_state      = IDLE;
            next_settle_cnt = '0;
        end else if (dmd_rise) begin
            // Any DMD edge restarts blanking; a zero setting skips it entirely.
            if (settle_zero) begin
                next_state      = OPEN;
                next_settle_cnt = '0;
            end else begin
                next_state      = SETTLE;
                next_settle_cnt = settle;
            end
        end else begin
            case (state)
                SETTLE: begin
                    if (settle_cnt <= ST_W'(1)) begin
                        next_state      = OPEN;
                        next_settle_cnt = '0;
                    end else begin
                        next_settle_cnt = settle_cnt - ST_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PPC_DEADTIME_EN
    logic [DT_W-1:0] holdoff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            holdoff <= '0;
        end else if (!enable) begin
            holdoff <= '0;
        end else if (accept) begin
            holdoff <= deadtime;
        end else if (holdoff != '0) begin
            holdoff <= holdoff - DT_W'(1);
        end
    end

    assign holdoff_clear = (holdoff == '0);
`else
    logic unused_deadtime;

    assign unused_deadtime = ^deadtime;
    assign holdoff_clear   = 1'b1;
`endif

    // A DMD edge coinciding with a photon blanks it unless blanking is zero-length.
    assign accept = photon_rise & enable & (state == OPEN) & holdoff_clear
                  & ~(dmd_rise & ~settle_zero);
    assign reject = photon_rise & enable & (state != IDLE) & ~accept;
    assign tick   = dmd_rise & enable;

    always_comb begin
        reject_sum = reject_cnt;
        if (reject && (reject_cnt != '1)) begin
            reject_sum = reject_cnt + REJ_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            photon_pulse <= 1'b0;
            frame_tick   <= 1'b0;
            window       <= 1'b0;
            reject_cnt   <= '0;
            reject_last  <= '0;
        end else begin
            photon_pulse <= accept;
            frame_tick   <= tick;
            window       <= (next_state == OPEN);
            // A reject landing with the frame tick belongs to the closing frame.
            if (tick) begin
                reject_last <= reject_sum;
                reject_cnt  <= '0;
            end else begin
                reject_cnt  <= reject_sum;
            end
        end
    end

endmodule

// File: tb/tb_photon_pulse_conditioner.sv
// Directed, table-driven bench for photon_pulse_conditioner; expectations
// follow PPC_DEADTIME_EN when the bench is compiled with it.
module tb_photon_pulse_conditioner;

    logic        clk;
    logic        rst_n;
    logic        sig;
    logic        DMD_sig;
    logic        enable;
    logic [7:0]  deadtime;
    logic [7:0]  settle;
    logic        photon_pulse;
    logic        frame_tick;
    logic        window;
    logic [15:0] reject_cnt;
    logic [15:0] reject_last;

    logic        s_photon_pulse;
    logic        s_frame_tick;
    logic        s_window;
    logic [2:0]  s_reject_cnt;
    logic [2:0]  s_reject_last;

    int n_cmp;
    int n_bad;

`ifdef PPC_DEADTIME_EN
    localparam int P  = 0;
    localparam int R1 = 1;
    localparam int R2 = 2;
`else
    localparam int P  = 1;
    localparam int R1 = 0;
    localparam int R2 = 0;
`endif

    photon_pulse_conditioner #(.DT_W(8), .ST_W(8), .REJ_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sig          (sig),
        .DMD_sig      (DMD_sig),
        .enable       (enable),
        .deadtime     (deadtime),
        .settle       (settle),
        .photon_pulse (photon_pulse),
        .frame_tick   (frame_tick),
        .window       (window),
        .reject_cnt   (reject_cnt),
        .reject_last  (reject_last)
    );

    // Narrow reject counters make saturation reachable in a few cycles.
    photon_pulse_conditioner #(.DT_W(8), .ST_W(8), .REJ_W(3)) dut_small (
        .clk          (clk),
        .rst_n        (rst_n),
        .sig          (sig),
        .DMD_sig      (DMD_sig),
        .enable       (enable),
        .deadtime     (deadtime),
        .settle       (settle),
        .photon_pulse (s_photon_pulse),
        .frame_tick   (s_frame_tick),
        .window       (s_window),
        .reject_cnt   (s_reject_cnt),
        .reject_last  (s_reject_last)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        logic        sig;
        logic        dmd;
        logic        en;
        logic [7:0]  st;
        logic [7:0]  dt;
        int          reps;
        logic        pp;
        logic        ft;
        logic        win;
        logic [15:0] rej;
        logic [15:0] last;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int s, input int d, input int e, input int st,
                       input int dt, input int reps, input int pp, input int ft,
                       input int win, input int rej, input int last);
        vec_t v;
        v.sig  = 1'(s);
        v.dmd  = 1'(d);
        v.en   = 1'(e);
        v.st   = 8'(st);
        v.dt   = 8'(dt);
        v.reps = reps;
        v.pp   = 1'(pp);
        v.ft   = 1'(ft);
        v.win  = 1'(win);
        v.rej  = 16'(rej);
        v.last = 16'(last);
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int row,
                         input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (row %0d, t=%0t): got %0h, expected %0h",
                     name, row, $time, act, exp);
        end
    endtask

    // Drive inputs on the falling edge, return just after the next rising edge.
    task automatic tick(input logic s, input logic d, input logic e,
                        input logic [7:0] st, input logic [7:0] dt);
        @(negedge clk);
        sig      = s;
        DMD_sig  = d;
        enable   = e;
        settle   = st;
        deadtime = dt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        sig      = 1'b0;
        DMD_sig  = 1'b0;
        enable   = 1'b1;
        settle   = 8'd4;
        deadtime = 8'd0;

        // Fields: sig dmd en settle deadtime reps | pp ft win rej last
        add(0,0,1,4,0,9, 0,0,0,0,0);    // e1-9 idle
        add(0,1,1,4,0,1, 0,0,0,0,0);    // e10 DMD sampled
        add(0,0,1,4,0,1, 0,0,0,0,0);
        add(0,0,1,4,0,1, 0,1,0,0,0);    // e12 frame_tick
        add(0,0,1,4,0,3, 0,0,0,0,0);    // e13-15 blanking
        add(0,0,1,4,0,4, 0,0,1,0,0);    // e16 window opens
        add(1,0,1,4,0,1, 0,0,1,0,0);    // e20 photon sampled
        add(0,0,1,4,0,1, 0,0,1,0,0);
        add(0,0,1,4,0,1, 1,0,1,0,0);    // e22 photon_pulse
        add(0,0,1,8,0,1, 0,0,1,0,0);
        add(0,1,1,8,0,1, 0,0,1,0,0);    // e24 DMD, settle=8
        add(0,0,1,8,0,1, 0,0,1,0,0);
        add(1,0,1,8,0,1, 0,1,0,0,0);    // e26 tick, photon in SETTLE
        add(0,0,1,8,0,1, 0,0,0,0,0);
        add(1,0,1,8,0,1, 0,0,0,1,0);
        add(0,0,1,8,0,1, 0,0,0,1,0);
        add(1,0,1,8,0,1, 0,0,0,2,0);
        add(0,0,1,8,0,1, 0,0,0,2,0);
        add(0,0,1,8,0,2, 0,0,0,3,0);    // e32-33 three rejects
        add(0,0,1,8,0,3, 0,0,1,3,0);    // e34 open again
        add(0,0,1,2,0,1, 0,0,1,3,0);
        add(0,1,1,2,0,1, 0,0,1,3,0);    // e38 DMD, settle=2
        add(0,0,1,2,0,1, 0,0,1,3,0);
        add(0,0,1,2,0,1, 0,1,0,0,3);    // e40 reject_last latched
        add(0,0,1,2,0,1, 0,0,0,0,3);
        add(0,0,1,2,0,2, 0,0,1,0,3);
        add(1,1,1,2,0,1, 0,0,1,0,3);    // e44 simultaneous, settle>0
        add(0,0,1,2,0,1, 0,0,1,0,3);
        add(0,0,1,2,0,1, 0,1,0,0,1);    // e46 reject goes to closing frame
        add(0,0,1,2,0,1, 0,0,0,0,1);
        add(0,0,1,2,0,1, 0,0,1,0,1);
        add(0,0,1,0,0,1, 0,0,1,0,1);
        add(1,1,1,0,0,1, 0,0,1,0,1);    // e50 simultaneous, settle=0
        add(0,0,1,0,0,1, 0,0,1,0,1);
        add(0,0,1,0,0,1, 1,1,1,0,0);    // e52 both strobes
        add(0,0,1,0,5,1, 0,0,1,0,0);
        add(1,0,1,0,5,1, 0,0,1,0,0);    // e54 photon train, deadtime=5
        add(0,0,1,0,5,1, 0,0,1,0,0);
        add(0,0,1,0,5,1, 1,0,1,0,0);
        add(1,0,1,0,5,1, 0,0,1,0,0);
        add(0,0,1,0,5,1, 0,0,1,0,0);
        add(0,0,1,0,5,1, P,0,1,R1,0);
        add(1,0,1,0,5,1, 0,0,1,R1,0);
        add(0,0,1,0,5,1, 0,0,1,R1,0);
        add(0,0,1,0,5,1, 1,0,1,R1,0);
        add(1,0,1,0,5,1, 0,0,1,R1,0);
        add(0,0,1,0,5,1, 0,0,1,R1,0);
        add(0,0,1,0,5,1, P,0,1,R2,0);
        add(1,0,1,0,5,1, 0,0,1,R2,0);
        add(0,0,1,0,5,1, 0,0,1,R2,0);
        add(0,0,1,0,5,1, 1,0,1,R2,0);
        add(0,0,1,0,5,1, 0,0,1,R2,0);
        add(0,0,0,0,5,1, 0,0,0,R2,0);   // e70 enable dropped
        add(1,1,0,0,5,1, 0,0,0,R2,0);
        add(0,0,0,0,5,1, 0,0,0,R2,0);
        add(1,0,0,0,5,1, 0,0,0,R2,0);
        add(0,0,0,0,5,3, 0,0,0,R2,0);
        add(0,0,1,0,5,1, 0,0,0,R2,0);   // e77 re-enabled, still IDLE
        add(1,0,1,0,5,1, 0,0,0,R2,0);
        add(0,0,1,0,5,3, 0,0,0,R2,0);
        add(0,1,1,0,5,1, 0,0,0,R2,0);   // e82 DMD
        add(0,0,1,0,5,1, 0,0,0,R2,0);
        add(0,0,1,0,5,1, 0,1,1,0,R2);
        add(0,0,1,0,5,1, 0,0,1,0,R2);
        add(1,0,1,0,5,1, 0,0,1,0,R2);
        add(0,0,1,0,5,1, 0,0,1,0,R2);
        add(0,0,1,0,5,1, 1,0,1,0,R2);   // e88 accepted after re-open
        add(0,0,1,0,5,1, 0,0,1,0,R2);

        #3;
        check("reset_photon_pulse", -1, 32'(photon_pulse), 32'd0);
        check("reset_frame_tick",   -1, 32'(frame_tick),   32'd0);
        check("reset_window",       -1, 32'(window),       32'd0);
        check("reset_reject_cnt",   -1, 32'(reject_cnt),   32'd0);
        check("reset_reject_last",  -1, 32'(reject_last),  32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                tick(vecs[i].sig, vecs[i].dmd, vecs[i].en, vecs[i].st, vecs[i].dt);
                check("photon_pulse", i, 32'(photon_pulse), 32'(vecs[i].pp));
                check("frame_tick",   i, 32'(frame_tick),   32'(vecs[i].ft));
                check("window",       i, 32'(window),       32'(vecs[i].win));
                check("reject_cnt",   i, 32'(reject_cnt),   32'(vecs[i].rej));
                check("reject_last",  i, 32'(reject_last),  32'(vecs[i].last));
            end
        end

        // Saturation: ten rejects inside a long blanking window.
        tick(1'b0, 1'b1, 1'b1, 8'd40, 8'd0);
        tick(1'b0, 1'b0, 1'b1, 8'd40, 8'd0);
        for (int k = 0; k < 10; k++) begin
            tick(1'b1, 1'b0, 1'b1, 8'd40, 8'd0);
            tick(1'b0, 1'b0, 1'b1, 8'd40, 8'd0);
        end
        tick(1'b0, 1'b0, 1'b1, 8'd40, 8'd0);
        tick(1'b0, 1'b0, 1'b1, 8'd40, 8'd0);
        check("sat_wide_reject_cnt",  100, 32'(reject_cnt),   32'd10);
        check("sat_small_reject_cnt", 100, 32'(s_reject_cnt), 32'd7);
        check("sat_window_blanked",   100, 32'(window),       32'd0);
        check("sat_no_pulse",         100, 32'(photon_pulse), 32'd0);

        begin
            int waited;
            waited = 0;
            while (!window && waited < 60) begin
                tick(1'b0, 1'b0, 1'b1, 8'd40, 8'd0);
                waited++;
            end
            check("window_reopen", 101, 32'(window), 32'd1);
        end

        // Asynchronous reset in the middle of a clock cycle.
        #5;
        rst_n = 1'b0;
        #1;
        check("async_photon_pulse", 102, 32'(photon_pulse), 32'd0);
        check("async_frame_tick",   102, 32'(frame_tick),   32'd0);
        check("async_window",       102, 32'(window),       32'd0);
        check("async_reject_cnt",   102, 32'(reject_cnt),   32'd0);
        check("async_reject_last",  102, 32'(reject_last),  32'd0);
        check("async_small_rej",    102, 32'(s_reject_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
